// File: rtl/seg7_scan_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_scan_decoder_if
//  Purpose  : Display-pin inputs, decoded digit outputs and frame handshake
//  Revision : 1.0  initial release
// ============================================================================
interface seg7_scan_decoder_if #(
   parameter int DIGITS = 4
);
   logic [6:0]          seg_in;
   logic [DIGITS-1:0]   an_in;
   logic [4*DIGITS-1:0] hex_out;
   logic [DIGITS-1:0]   dig_valid;
   logic [DIGITS-1:0]   err;
   logic [4*DIGITS-1:0] frame_hex;
   logic                frame_vld;
   logic                frame_rdy;
   logic                overrun;

   modport master (
      output seg_in, an_in, frame_rdy,
      input  hex_out, dig_valid, err, frame_hex, frame_vld, overrun
   );

   modport slave (
      input  seg_in, an_in, frame_rdy,
      output hex_out, dig_valid, err, frame_hex, frame_vld, overrun
   );
endinterface
`default_nettype wire

// File: rtl/seg7_scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_scan_decoder
//  Purpose  : Qualifies multiplexed 7-segment digits, decodes them to hex and
//             publishes complete frames on a valid/ready handshake
//  Revision : 1.0  initial release
// ============================================================================
module seg7_scan_decoder #(
   parameter int DIGITS     = 4,
   parameter int STABLE_CYC = 4
) (
   input  wire logic          clk,
   input  wire logic          rst,
   seg7_scan_decoder_if.slave bus
);

   localparam int CW = $clog2(STABLE_CYC + 1);
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CW-1:0] c_stable = CW'(STABLE_CYC);
   localparam logic [CW-1:0] c_one    = CW'(1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_HELD   = 2'd2
   } state_t;

   state_t              r_state;
   logic [CW-1:0]       r_cnt;
   logic [6:0]          r_seg_s1, r_seg_s2, r_seg_prev;
   logic [DIGITS-1:0]   r_an_s1, r_an_s2, r_an_prev;
   logic [4*DIGITS-1:0] r_hex;
   logic [DIGITS-1:0]   r_valid;
   logic [DIGITS-1:0]   r_err;
   logic [DIGITS-1:0]   r_seen;
   logic [4*DIGITS-1:0] r_frame_hex;
   logic                r_frame_vld;
   logic                r_overrun;

   logic [DIGITS-1:0]   w_an_low;
   logic                w_one_low;
   logic                w_changed;
   logic                w_accept;
   logic [IW-1:0]       w_idx;
   logic [4:0]          w_dec;
   logic [4*DIGITS-1:0] w_hex_next;
   logic [DIGITS-1:0]   w_valid_next;
   logic [DIGITS-1:0]   w_err_next;
   logic [DIGITS-1:0]   w_seen_next;
   logic                w_frame_done;

   // Returns {legal, value}; segment lines are active-low, bit 6 = g.
   function automatic logic [4:0] f_decode(input logic [6:0] seg);
      logic [4:0] v;
      case (seg)
         7'h40:   v = 5'h10;
         7'h79:   v = 5'h11;
         7'h24:   v = 5'h12;
         7'h30:   v = 5'h13;
         7'h19:   v = 5'h14;
         7'h12:   v = 5'h15;
         7'h02:   v = 5'h16;
         7'h78:   v = 5'h17;
         7'h00:   v = 5'h18;
         7'h10:   v = 5'h19;
         7'h08:   v = 5'h1A;
         7'h03:   v = 5'h1B;
         7'h46:   v = 5'h1C;
         7'h21:   v = 5'h1D;
         7'h06:   v = 5'h1E;
         7'h0E:   v = 5'h1F;
         default: v = 5'h00;
      endcase
      return v;
   endfunction

   assign w_an_low  = ~r_an_s2;
   assign w_one_low = (w_an_low != '0) && ((w_an_low & (w_an_low - DIGITS'(1))) == '0);
   assign w_changed = (r_seg_s2 != r_seg_prev) || (r_an_s2 != r_an_prev);
   assign w_accept  = (r_state == S_SETTLE) && !w_changed && ((r_cnt + c_one) == c_stable);

   always_comb begin
      w_idx = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (w_an_low[i]) w_idx = IW'(i);
      end
   end

   always_comb begin
      w_dec        = f_decode(r_seg_s2);
      w_hex_next   = r_hex;
      w_valid_next = r_valid;
      w_err_next   = r_err;
      w_seen_next  = r_seen;
      if (w_accept) begin
         w_seen_next[w_idx] = 1'b1;
         if (w_dec[4]) begin
            w_hex_next[{w_idx, 2'b00} +: 4] = w_dec[3:0];
            w_valid_next[w_idx]             = 1'b1;
            w_err_next[w_idx]               = 1'b0;
         end else if (r_seg_s2 == 7'h7F) begin
            w_valid_next[w_idx] = 1'b0;
            w_err_next[w_idx]   = 1'b0;
         end else begin
            w_err_next[w_idx] = 1'b1;
         end
      end
   end

   assign w_frame_done = w_accept && (w_seen_next == '1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_seg_s1    <= 7'h7F;
         r_seg_s2    <= 7'h7F;
         r_seg_prev  <= 7'h7F;
         r_an_s1     <= '1;
         r_an_s2     <= '1;
         r_an_prev   <= '1;
         r_hex       <= '0;
         r_valid     <= '0;
         r_err       <= '0;
         r_seen      <= '0;
         r_frame_hex <= '0;
         r_frame_vld <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_seg_s1   <= bus.seg_in;
         r_seg_s2   <= r_seg_s1;
         r_seg_prev <= r_seg_s2;
         r_an_s1    <= bus.an_in;
         r_an_s2    <= r_an_s1;
         r_an_prev  <= r_an_s2;

         case (r_state)
            S_IDLE: begin
               if (w_one_low) begin
                  r_state <= S_SETTLE;
                  r_cnt   <= c_one;
               end else begin
                  r_cnt   <= '0;
               end
            end
            S_SETTLE: begin
               if (w_changed) begin
                  if (w_one_low) begin
                     r_cnt   <= c_one;
                  end else begin
                     r_state <= S_IDLE;
                     r_cnt   <= '0;
                  end
               end else if (w_accept) begin
                  r_state <= S_HELD;
                  r_cnt   <= c_stable;
               end else begin
                  r_cnt   <= r_cnt + c_one;
               end
            end
            S_HELD: begin
               if (w_changed) begin
                  if (w_one_low) begin
                     r_state <= S_SETTLE;
                     r_cnt   <= c_one;
                  end else begin
                     r_state <= S_IDLE;
                     r_cnt   <= '0;
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_cnt   <= '0;
            end
         endcase

         r_hex   <= w_hex_next;
         r_valid <= w_valid_next;
         r_err   <= w_err_next;

         // A completing frame wins over the handshake: it reloads the snapshot in the same cycle.
         if (w_frame_done) begin
            r_seen <= '0;
            if (!r_frame_vld || bus.frame_rdy) begin
               r_frame_hex <= w_hex_next;
               r_frame_vld <= 1'b1;
               r_overrun   <= 1'b0;
            end else begin
               r_overrun   <= 1'b1;
            end
         end else begin
            r_seen <= w_seen_next;
            if (r_frame_vld && bus.frame_rdy) begin
               r_frame_vld <= 1'b0;
               r_overrun   <= 1'b0;
            end
         end
      end
   end

   assign bus.hex_out   = r_hex;
   assign bus.dig_valid = r_valid;
   assign bus.err       = r_err;
   assign bus.frame_hex = r_frame_hex;
   assign bus.frame_vld = r_frame_vld;
   assign bus.overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg7_scan_decoder
//  Purpose  : Directed vector bench for seg7_scan_decoder
//  Revision : 1.0  initial release
// ============================================================================
module tb_seg7_scan_decoder;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_failed;
   int   pulses;
   logic vld_q;

   seg7_scan_decoder_if #(.DIGITS(4)) bus ();

   seg7_scan_decoder #(.DIGITS(4), .STABLE_CYC(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst) begin
         pulses = 0;
         vld_q  = 1'b0;
      end else begin
         if (bus.frame_vld && !vld_q) pulses = pulses + 1;
         vld_q = bus.frame_vld;
      end
   end

   typedef struct {
      logic [6:0]  seg;
      logic [3:0]  an;
      int          cyc;
      logic        rdy;
      logic [15:0] hex;
      logic [3:0]  vld;
      logic [3:0]  err;
      logic [15:0] fhex;
      logic        fvld;
      logic        ovr;
   } vec_t;

   vec_t vecs[28];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests = n_tests + 1;
      if (act !== exp) begin
         n_failed = n_failed + 1;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [15:0] hex, input logic [3:0] vld,
                          input logic [3:0] err, input logic [15:0] fhex, input logic fvld,
                          input logic ovr);
      chk({tag, "_hex"},  32'(bus.hex_out),   32'(hex));
      chk({tag, "_dv"},   32'(bus.dig_valid), 32'(vld));
      chk({tag, "_err"},  32'(bus.err),       32'(err));
      chk({tag, "_fhex"}, 32'(bus.frame_hex), 32'(fhex));
      chk({tag, "_fvld"}, 32'(bus.frame_vld), 32'(fvld));
      chk({tag, "_ovr"},  32'(bus.overrun),   32'(ovr));
   endtask

   task automatic drive(input logic [6:0] seg, input logic [3:0] an, input int n);
      bus.seg_in = seg;
      bus.an_in  = an;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      n_tests  = 0;
      n_failed = 0;
      pulses   = 0;
      vld_q    = 1'b0;

      // scan "1A3F" twice with RDY=1
      vecs[0]  = '{7'h79, 4'b1110, 8, 1'b1, 16'h0001, 4'h1, 4'h0, 16'h0000, 1'b0, 1'b0};
      vecs[1]  = '{7'h08, 4'b1101, 8, 1'b1, 16'h00A1, 4'h3, 4'h0, 16'h0000, 1'b0, 1'b0};
      vecs[2]  = '{7'h30, 4'b1011, 8, 1'b1, 16'h03A1, 4'h7, 4'h0, 16'h0000, 1'b0, 1'b0};
      vecs[3]  = '{7'h0E, 4'b0111, 8, 1'b1, 16'hF3A1, 4'hF, 4'h0, 16'hF3A1, 1'b0, 1'b0};
      vecs[4]  = '{7'h79, 4'b1110, 8, 1'b1, 16'hF3A1, 4'hF, 4'h0, 16'hF3A1, 1'b0, 1'b0};
      vecs[5]  = '{7'h08, 4'b1101, 8, 1'b1, 16'hF3A1, 4'hF, 4'h0, 16'hF3A1, 1'b0, 1'b0};
      vecs[6]  = '{7'h30, 4'b1011, 8, 1'b1, 16'hF3A1, 4'hF, 4'h0, 16'hF3A1, 1'b0, 1'b0};
      vecs[7]  = '{7'h0E, 4'b0111, 8, 1'b1, 16'hF3A1, 4'hF, 4'h0, 16'hF3A1, 1'b0, 1'b0};
      // digit 2 held only 3 cycles: no accept, frame waits for the next scan
      vecs[8]  = '{7'h24, 4'b1110, 8, 1'b1, 16'hF3A2, 4'hF, 4'h0, 16'hF3A1, 1'b0, 1'b0};
      vecs[9]  = '{7'h19, 4'b1101, 8, 1'b1, 16'hF342, 4'hF, 4'h0, 16'hF3A1, 1'b0, 1'b0};
      vecs[10] = '{7'h02, 4'b1011, 3, 1'b1, 16'hF342, 4'hF, 4'h0, 16'hF3A1, 1'b0, 1'b0};
      vecs[11] = '{7'h78, 4'b0111, 8, 1'b1, 16'h7342, 4'hF, 4'h0, 16'hF3A1, 1'b0, 1'b0};
      vecs[12] = '{7'h00, 4'b1110, 8, 1'b1, 16'h7348, 4'hF, 4'h0, 16'hF3A1, 1'b0, 1'b0};
      vecs[13] = '{7'h10, 4'b1101, 8, 1'b1, 16'h7398, 4'hF, 4'h0, 16'hF3A1, 1'b0, 1'b0};
      vecs[14] = '{7'h08, 4'b1011, 8, 1'b1, 16'h7A98, 4'hF, 4'h0, 16'h7A98, 1'b0, 1'b0};
      vecs[15] = '{7'h21, 4'b0111, 8, 1'b1, 16'hDA98, 4'hF, 4'h0, 16'h7A98, 1'b0, 1'b0};
      // illegal glyph, recovery, blank
      vecs[16] = '{7'h55, 4'b1110, 8, 1'b1, 16'hDA98, 4'hF, 4'h1, 16'h7A98, 1'b0, 1'b0};
      vecs[17] = '{7'h40, 4'b1110, 8, 1'b1, 16'hDA90, 4'hF, 4'h0, 16'h7A98, 1'b0, 1'b0};
      vecs[18] = '{7'h7F, 4'b1110, 8, 1'b1, 16'hDA90, 4'hE, 4'h0, 16'h7A98, 1'b0, 1'b0};
      // RDY=0: first frame held, second frame dropped
      vecs[19] = '{7'h46, 4'b1101, 8, 1'b0, 16'hDAC0, 4'hE, 4'h0, 16'h7A98, 1'b0, 1'b0};
      vecs[20] = '{7'h03, 4'b1011, 8, 1'b0, 16'hDBC0, 4'hE, 4'h0, 16'hDBC0, 1'b1, 1'b0};
      vecs[21] = '{7'h06, 4'b1110, 8, 1'b0, 16'hDBCE, 4'hF, 4'h0, 16'hDBC0, 1'b1, 1'b0};
      vecs[22] = '{7'h79, 4'b1101, 8, 1'b0, 16'hDB1E, 4'hF, 4'h0, 16'hDBC0, 1'b1, 1'b0};
      vecs[23] = '{7'h12, 4'b1011, 8, 1'b0, 16'hD51E, 4'hF, 4'h0, 16'hDBC0, 1'b1, 1'b0};
      vecs[24] = '{7'h0E, 4'b0111, 8, 1'b0, 16'hF51E, 4'hF, 4'h0, 16'hDBC0, 1'b1, 1'b1};
      vecs[25] = '{7'h7F, 4'b1111, 1, 1'b1, 16'hF51E, 4'hF, 4'h0, 16'hDBC0, 1'b0, 1'b0};
      // illegal anode patterns: nothing accepted
      vecs[26] = '{7'h19, 4'b1100, 20, 1'b1, 16'hF51E, 4'hF, 4'h0, 16'hDBC0, 1'b0, 1'b0};
      vecs[27] = '{7'h19, 4'b1111, 20, 1'b1, 16'hF51E, 4'hF, 4'h0, 16'hDBC0, 1'b0, 1'b0};

      rst           = 1'b1;
      bus.seg_in    = 7'h7F;
      bus.an_in     = 4'hF;
      bus.frame_rdy = 1'b1;
      repeat (3) @(negedge clk);
      chk_all("reset", 16'h0, 4'h0, 4'h0, 16'h0, 1'b0, 1'b0);
      rst = 1'b0;

      for (int k = 0; k < 28; k++) begin
         bus.frame_rdy = vecs[k].rdy;
         drive(vecs[k].seg, vecs[k].an, vecs[k].cyc);
         chk_all($sformatf("row%0d", k), vecs[k].hex, vecs[k].vld, vecs[k].err,
                 vecs[k].fhex, vecs[k].fvld, vecs[k].ovr);
         if (k == 7) chk("frame_pulses_two_scans", 32'(pulses), 32'd2);
      end

      // single-cycle glitch inside a stable window restarts the count
      drive(7'h24, 4'b1110, 3);
      drive(7'h55, 4'b1110, 1);
      drive(7'h24, 4'b1110, 3);
      drive(7'h7F, 4'b1111, 4);
      chk("glitch_hex", 32'(bus.hex_out), 32'h0000_F51E);
      chk("glitch_err", 32'(bus.err), 32'h0);
      drive(7'h24, 4'b1110, 4);
      drive(7'h7F, 4'b1111, 3);
      chk("after_glitch_hex", 32'(bus.hex_out), 32'h0000_F512);

      // asynchronous reset mid-scan clears everything without a clock edge
      drive(7'h0E, 4'b0111, 2);
      #2;
      rst = 1'b1;
      #1;
      chk_all("async_rst", 16'h0, 4'h0, 4'h0, 16'h0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      drive(7'h79, 4'b1110, 5);
      chk("post_rst_early_dv", 32'(bus.dig_valid), 32'h0);
      drive(7'h79, 4'b1110, 1);
      chk("post_rst_first_dv", 32'(bus.dig_valid), 32'h1);
      chk("post_rst_first_hex", 32'(bus.hex_out), 32'h0001);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
      $finish;
   end

endmodule
`default_nettype wire
